// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - byte-side handshake between the PS/2 receiver and its consumer
// The receiver drives through master; the consumer pops through slave.
interface ps2_keyboard_rx_if;
   logic       rd_en;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       err;

   modport master (
      input  rd_en,
      output data,
      output ready,
      output overflow,
      output err
   );

   modport slave (
      output rd_en,
      input  data,
      input  ready,
      input  overflow,
      input  err
   );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 device-to-host frame receiver feeding a FWFT byte FIFO
// Optional mid-frame idle timeout enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_keyboard_rx #(
   parameter int FIFO_AW = 3
`ifdef PS2_RX_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 50000
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   ps2_keyboard_rx_if.master   bus
);
   localparam int PW    = FIFO_AW + 1;
   localparam int DEPTH = 1 << FIFO_AW;

   logic          clk_s1_q, clk_s1_d, clk_sync_q, clk_sync_d, clk_hist_q, clk_hist_d;
   logic          dat_s1_q, dat_s1_d, dat_sync_q, dat_sync_d;
   logic [10:0]   frame_q, frame_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic          done_q, done_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic          err_q, err_d, overflow_q, overflow_d;
   logic          fall, frame_ok, empty, full, pop, push, to_hit;

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   always_comb begin
      to_cnt_d = to_cnt_q;
      to_hit   = 1'b0;
      if (bit_cnt_q == 4'd0 || fall) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
         to_cnt_d = '0;
         to_hit   = 1'b1;
      end else begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) to_cnt_q <= '0;
      else     to_cnt_q <= to_cnt_d;
   end
`else
   assign to_hit = 1'b0;
`endif

   assign fall     = clk_hist_q & ~clk_sync_q;
   // frame_q holds start in bit 0 and stop in bit 10 once all 11 bits are in
   assign frame_ok = ~frame_q[0] & frame_q[10] & (^frame_q[9:1]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q == {~rd_ptr_q[PW-1], rd_ptr_q[PW-2:0]});
   assign pop      = bus.rd_en & ~empty;
   assign push     = done_q & frame_ok & (~full | pop);

   always_comb begin
      clk_s1_d   = ps2_clk;
      clk_sync_d = clk_s1_q;
      clk_hist_d = clk_sync_q;
      dat_s1_d   = ps2_data;
      dat_sync_d = dat_s1_q;
      frame_d    = frame_q;
      bit_cnt_d  = bit_cnt_q;
      done_d     = 1'b0;
      if (fall) begin
         frame_d = {dat_sync_q, frame_q[10:1]};
         if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            done_d    = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (to_hit) begin
         bit_cnt_d = 4'd0;
      end
   end

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      err_d      = err_q | (done_q & ~frame_ok) | to_hit;
      overflow_d = overflow_q | (done_q & frame_ok & full & ~pop);
      if (push) begin
         mem_d[wr_ptr_q[FIFO_AW-1:0]] = frame_q[8:1];
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_hist_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_sync_q <= 1'b1;
         frame_q    <= '0;
         bit_cnt_q  <= 4'd0;
         done_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         clk_s1_q   <= clk_s1_d;
         clk_sync_q <= clk_sync_d;
         clk_hist_q <= clk_hist_d;
         dat_s1_q   <= dat_s1_d;
         dat_sync_q <= dat_sync_d;
         frame_q    <= frame_d;
         bit_cnt_q  <= bit_cnt_d;
         done_q     <= done_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         err_q      <= err_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.ready    = ~empty;
   assign bus.data     = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign bus.err      = err_q;
   assign bus.overflow = overflow_q;
endmodule
